conv_bcd_bin_seq: RTL and testbench

Sequential, parametrised BCD/binary converter between the PicoBlaze ports and the time/date registers. It converts in both directions, selected per request:
- BCD to binary uses reverse double-dabble.
- Binary to BCD uses double-dabble.
It replaces fixed lookup decoding with one iteration per clock, a start/busy/done handshake, and range/validity checking against a programmable maximum value.

---
 rtl/conv_bcd_bin_seq_pkg.sv | 25 ++
 rtl/conv_bcd_bin_seq_ajuste_digito.sv | 19 +
 rtl/conv_bcd_bin_seq.sv | 139 +++++++++++++
 tb/tb_conv_bcd_bin_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_bcd_bin_seq_pkg.sv
// Shared constants and elaboration-time helpers for the sequential BCD/binary converter.
package conv_bcd_bin_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic MODE_BCD2BIN = 1'b0;
    localparam logic MODE_BIN2BCD = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/conv_bcd_bin_seq_ajuste_digito.sv
// Per-nibble dabble correction: +3 when building BCD, -3 when unpacking BCD.
module ajuste_digito
    import conv_bcd_bin_seq_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dir,
    output logic [3:0] result
);

    always_comb begin
        result = nibble;
        if (dir == MODE_BIN2BCD) begin
            if (nibble >= 4'd5) result = nibble + 4'd3;
        end else begin
            if (nibble >= 4'd8) result = nibble - 4'd3;
        end
    end

endmodule

// File: rtl/conv_bcd_bin_seq.sv
// Iterative BCD<->binary converter, one dabble step per clock, with range checking.
//   state | meaning
//   IDLE  | waiting for start; operand validated and latched on start
//   CONV  | one shift/correct iteration per cycle, counter runs down from W_BIN
//   FIN   | done pulse, result (or error) presented, back to IDLE
module conv_bcd_bin_seq
    import conv_bcd_bin_seq_pkg::*;
#(
    parameter int N_DIG   = 2,
    parameter int W_BIN   = 8,
    parameter int MAX_VAL = 59
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [4*N_DIG-1:0] bcd_in,
    input  logic [W_BIN-1:0]   bin_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [W_BIN-1:0]   bin_out,
    output logic [4*N_DIG-1:0] bcd_out
);

    localparam int BCD_W   = 4 * N_DIG;
    localparam int SR_W    = BCD_W + W_BIN;
    localparam int CNT_W   = clog2(W_BIN + 1);
    // A BCD operand can never exceed 10^N_DIG-1, so the limit is clamped there.
    localparam int BCD_MAX = (MAX_VAL < pow10(N_DIG)) ? MAX_VAL : pow10(N_DIG) - 1;

    logic [1:0]       state;
    logic             mode_r;
    logic [SR_W-1:0]  sr;
    logic [CNT_W-1:0] cnt;

    logic [SR_W-1:0]  sr_shr;
    logic [SR_W-1:0]  sr_next;
    logic [BCD_W-1:0] adj_src;
    logic [BCD_W-1:0] adj_res;
    logic [31:0]      dec_val;
    logic             nib_bad;
    logic             op_bad;

    assign sr_shr  = sr >> 1;
    assign adj_src = (mode_r == MODE_BIN2BCD) ? sr[SR_W-1 -: BCD_W] : sr_shr[SR_W-1 -: BCD_W];

    for (genvar g = 0; g < N_DIG; g++) begin : g_adj
        ajuste_digito u_adj (
            .nibble (adj_src[4*g +: 4]),
            .dir    (mode_r),
            .result (adj_res[4*g +: 4])
        );
    end

    // Forward: correct then shift left. Reverse: shift right then correct.
    always_comb begin
        if (mode_r == MODE_BIN2BCD)
            sr_next = {adj_res, sr[W_BIN-1:0]} << 1;
        else
            sr_next = {adj_res, sr_shr[W_BIN-1:0]};
    end

    always_comb begin
        dec_val = '0;
        nib_bad = 1'b0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            dec_val = dec_val * 32'd10 + 32'(bcd_in[4*i +: 4]);
            if (bcd_in[4*i +: 4] > 4'd9) nib_bad = 1'b1;
        end
        if (mode == MODE_BCD2BIN)
            op_bad = nib_bad || (dec_val > 32'(BCD_MAX));
        else
            op_bad = (32'(bin_in) > 32'(MAX_VAL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            mode_r  <= MODE_BCD2BIN;
            sr      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_r  <= mode;
                        err     <= 1'b0;
                        bin_out <= '0;
                        bcd_out <= '0;
                        if (mode == MODE_BCD2BIN)
                            sr <= {bcd_in, {W_BIN{1'b0}}};
                        else
                            sr <= {{BCD_W{1'b0}}, bin_in};
                        if (op_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            busy  <= 1'b1;
                            cnt   <= CNT_W'(W_BIN);
                            state <= ST_CONV;
                        end
                    end
                end
                ST_CONV: begin
                    sr  <= sr_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
                        if (mode_r == MODE_BIN2BCD)
                            bcd_out <= sr_next[SR_W-1 -: BCD_W];
                        else
                            bin_out <= sr_next[W_BIN-1:0];
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_bcd_bin_seq.sv
// Self-checking bench: arithmetic transaction model checked every cycle plus literal vectors.
module tb_conv_bcd_bin_seq;

    localparam int N_DIG   = 2;
    localparam int W_BIN   = 8;
    localparam int MAX_VAL = 59;
    localparam int BCD_W   = 4 * N_DIG;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [BCD_W-1:0] bcd_in = '0;
    logic [W_BIN-1:0] bin_in = '0;
    logic             busy, done, err;
    logic [W_BIN-1:0] bin_out;
    logic [BCD_W-1:0] bcd_out;

    always #5 clk = ~clk;

    conv_bcd_bin_seq #(.N_DIG(N_DIG), .W_BIN(W_BIN), .MAX_VAL(MAX_VAL)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .bcd_in  (bcd_in),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out),
        .bcd_out (bcd_out)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    function automatic bit bcd_ok(input logic [BCD_W-1:0] b);
        bit ok = 1'b1;
        for (int i = 0; i < N_DIG; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic int bcd_val(input logic [BCD_W-1:0] b);
        int v = 0;
        for (int i = N_DIG - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [BCD_W-1:0] to_bcd(input int value);
        logic [BCD_W-1:0] r = '0;
        int v = value;
        for (int i = 0; i < N_DIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit is_bad(input logic md, input logic [BCD_W-1:0] b, input logic [W_BIN-1:0] n);
        if (md == 1'b0) return !bcd_ok(b) || (bcd_val(b) > MAX_VAL);
        return int'(n) > MAX_VAL;
    endfunction

    // Transaction model: m_remain counts cycles until the done cycle (0 = idle).
    int               m_remain = 0;
    logic             m_mode = 1'b0;
    logic             m_err = 1'b0;
    logic [W_BIN-1:0] m_bin = '0;
    logic [W_BIN-1:0] m_res_bin = '0;
    logic [BCD_W-1:0] m_bcd = '0;
    logic [BCD_W-1:0] m_res_bcd = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_remain <= 0;
            m_err    <= 1'b0;
            m_bin    <= '0;
            m_bcd    <= '0;
        end else if (m_remain == 0) begin
            if (start) begin
                m_mode    <= mode;
                m_bin     <= '0;
                m_bcd     <= '0;
                m_err     <= is_bad(mode, bcd_in, bin_in);
                m_res_bin <= W_BIN'(bcd_val(bcd_in));
                m_res_bcd <= to_bcd(int'(bin_in));
                m_remain  <= is_bad(mode, bcd_in, bin_in) ? 1 : W_BIN + 1;
            end
        end else begin
            m_remain <= m_remain - 1;
            if (m_remain == 2) begin
                if (m_mode) m_bcd <= m_res_bcd;
                else        m_bin <= m_res_bin;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if ({busy, done, err, bin_out, bcd_out} !==
                {m_remain >= 2, m_remain == 1, m_err, m_bin, m_bcd}) begin
                failures++;
                $display("FAIL cycle_model t=%0t actual busy=%b done=%b err=%b bin=%h bcd=%h required busy=%b done=%b err=%b bin=%h bcd=%h",
                         $time, busy, done, err, bin_out, bcd_out,
                         m_remain >= 2, m_remain == 1, m_err, m_bin, m_bcd);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue a request, scramble inputs afterwards, and measure latency to done.
    task automatic request(input logic md, input int opnd, output int lat);
        start = 1'b1;
        mode  = md;
        if (md) bin_in = W_BIN'(opnd);
        else    bcd_in = BCD_W'(opnd);
        tick();
        start  = 1'b0;
        mode   = ~md;
        bin_in = 8'hA5;
        bcd_in = 8'h3C;
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic req_check(input string name, input logic md, input int opnd, input int exp_lat,
                             input logic exp_err, input logic [W_BIN-1:0] exp_bin,
                             input logic [BCD_W-1:0] exp_bcd);
        int lat;
        request(md, opnd, lat);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_bin"}, 32'(bin_out), 32'(exp_bin));
        check({name, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        tick();
    endtask

    initial begin
        int ndone;
        int dcyc;
        int lat;
        logic [BCD_W-1:0] got_bcd;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        tick();
        check("reset_state", {27'd0, busy, done, err, |bin_out, |bcd_out}, 32'd0);

        req_check("b2d_59", 1'b1, 59, 9, 1'b0, 8'h00, 8'h59);
        req_check("d2b_47", 1'b0, 8'h47, 9, 1'b0, 8'h2F, 8'h00);
        req_check("d2b_00", 1'b0, 8'h00, 9, 1'b0, 8'h00, 8'h00);
        req_check("d2b_59", 1'b0, 8'h59, 9, 1'b0, 8'h3B, 8'h00);
        req_check("d2b_5A", 1'b0, 8'h5A, 1, 1'b1, 8'h00, 8'h00);
        req_check("d2b_60", 1'b0, 8'h60, 1, 1'b1, 8'h00, 8'h00);
        req_check("d2b_99", 1'b0, 8'h99, 1, 1'b1, 8'h00, 8'h00);
        req_check("b2d_60", 1'b1, 60, 1, 1'b1, 8'h00, 8'h00);
        req_check("b2d_00", 1'b1, 0, 9, 1'b0, 8'h00, 8'h00);
        req_check("b2d_37", 1'b1, 37, 9, 1'b0, 8'h00, 8'h37);

        // Extra start pulses while busy and during the done cycle must be ignored.
        ndone = 0;
        dcyc = 0;
        start = 1'b1;
        mode = 1'b1;
        bin_in = 8'd37;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (done) begin
                ndone++;
                dcyc = c;
            end
            start = (c == 2 || c == 9);
            if (c == 2) bin_in = 8'd12;
        end
        start = 1'b0;
        check("collide_ndone", ndone, 1);
        check("collide_cycle", dcyc, 9);
        check("collide_bcd", 32'(bcd_out), 32'h37);

        // Reset in mid-conversion aborts without a done pulse.
        start = 1'b1;
        mode = 1'b1;
        bin_in = 8'd37;
        for (int c = 1; c <= 3; c++) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b1;
        tick();
        check("abort_outputs", {27'd0, busy, done, err, |bin_out, |bcd_out}, 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        req_check("after_abort", 1'b1, 37, 9, 1'b0, 8'h00, 8'h37);

        // Full legal range both ways, closing the loop through the BCD result.
        for (int v = 0; v <= MAX_VAL; v++) begin
            request(1'b1, v, lat);
            check("sweep_b2d", 32'(bcd_out), 32'(((v / 10) << 4) | (v % 10)));
            got_bcd = bcd_out;
            tick();
            request(1'b0, int'(got_bcd), lat);
            check("sweep_d2b", 32'(bin_out), 32'(v));
            tick();
        end
        for (int v = MAX_VAL + 1; v <= MAX_VAL + 8; v++) begin
            request(1'b1, v, lat);
            check("sweep_b2d_err", {30'd0, err, |bcd_out}, 32'd2);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
